order_arb3: RTL and testbench
=============================

# order_arb3

Two-requester round-robin arbiter and scheduler for a shared registered 3-input sort stage. Each requester offers a triplet of unsigned words with a valid/ready handshake. The block grants one triplet per cycle, sorts it in descending order through one internal register stage, and tags each result with its requester id. Results are returned through a 3-entry output FIFO that is credit-protected against consumer backpressure. It sits between the sort clients and the shared sort resource.

## Interface
- DSIZE, 8, width of each unsigned data word
- CNTW, 16, width of grant counters (only with ORDER_ARB_CNT_EN)
- clock  in  1  single clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- req0_valid / req1_valid  in  1  requester offers a triplet
- req0_ready / req1_ready  out  1  triplet accepted this cycle when valid & ready
- req0_data0..2 / req1_data0..2  in  DSIZE each  triplet words
- res_valid  out  1  result word set available at FIFO head
- res_ready  in  1  consumer accepts head
- res_id  out  1  requester that issued the result
- res_data0..2  out  DSIZE each  sorted result, data0 max, data2 min
- grant_cnt0 / grant_cnt1  out  CNTW  accepted-triplet counts (macro-dependent)

## Operation
- Credit = 3 − fifo_count − stage_valid. Issue is permitted only when credit ≥ 1.
- Arbitration:
  - Only req0 valid: grant 0. Only req1 valid: grant 1.
  - Both valid: grant the requester not in last_grant.
  - last_grant updates only on an actual issue. Its reset value is 1, so req0 wins the first contention.
- reqN_ready = grantN & credit_ok. It is combinational from the valids and state, and is never asserted for both requesters in the same cycle. reqN_ready is also 0 when reqN_valid is 0.
- Sort stage:
  - On issue, the triplet is ordered descending with unsigned compare.
  - Ties keep input-index order: equal words are emitted with the lower index first.
  - The result and id are registered in the stage register, and stage_valid is set.
- FIFO:
  - A valid stage entry is pushed into the 3-deep FIFO on the next edge. Push is guaranteed by credit, so no overflow is possible.
  - Pop occurs when res_valid & res_ready.
  - Simultaneous push and pop leaves the count unchanged.
  - Results leave in issue order.
- Reset mid-operation discards all in-flight and buffered results.

## Timing
- Triplet accepted at cycle T (valid & ready high at the edge ending T).
- Result is in the stage register at T+1, at the FIFO head at T+2, and res_valid rises in T+2 if the FIFO was empty.
- Minimum latency is 2 cycles. Throughput is one triplet per cycle while res_ready stays high.
- With res_ready held low, at most 3 triplets are accepted, after which both reqN_ready stay 0.
- Reset values:
  - req0_ready, req1_ready, res_valid: 0.
  - res_id: 0. res_data0..2: 0.
  - fifo_count, stage_valid: 0. last_grant: 1. Grant counters: 0.
- res_* must hold stable while res_valid & !res_ready.

## Configuration
- ORDER_ARB_CNT_EN defined:
  - grant_cnt0/1 ports exist.
  - Each counter increments by 1 on its requester's accepted issue and wraps modulo 2^CNTW.
- ORDER_ARB_CNT_EN undefined: the ports and counter registers are absent. All other behaviour is identical.

## Structure
- Shared package order_pkg holds:
  - the DSIZE default;
  - the FIFO depth constant ORDER_ARB_FIFO_DEPTH = 3;
  - a result struct typedef {id, data0, data1, data2};
  - the requester id typedef.
- One sub-module, order_arb3_fifo: a 3-entry synchronous FIFO of result structs with push, pop, count and head outputs. It uses the same clock and asynchronous reset.
- The sort compare logic and arbiter stay in the top module.

## Test plan
- Single req0 triplet (5, 9, 2), res_ready=1 → accepted at T; res_valid at T+2 with data (9, 5, 2), id 0.
- Both requesters valid continuously for 4 cycles, res_ready=1 → grants alternate 0, 1, 0, 1; results return in that order, one per cycle.
- res_ready=0 with req0 streaming (1,2,3), (4,5,6), (7,8,9), (0,0,1) → exactly 3 accepts, then req0_ready stays 0. Raising res_ready drains (3,2,1), (6,5,4), (9,8,7), then the 4th is accepted and returns (1,0,0).
- Ties: (7, 7, 3) and (4, 4, 4) → (7, 7, 3) and (4, 4, 4) with no loss or duplication; the index-order tie rule is checked on tagged-bit inputs.
- rst_n pulled low with 2 results buffered and 1 in the stage → all outputs return to reset values asynchronously. After release, the first contention grants req0.
- With ORDER_ARB_CNT_EN: 5 req0 and 3 req1 accepts → grant_cnt0=5, grant_cnt1=3. With CNTW=2, 5 accepts give a wrapped count of 1.

Source files
------------

// File: rtl/order_pkg.sv
// Shared types and constants for the order_arb3 sort scheduler.
package order_pkg;
    localparam int ORDER_DSIZE          = 8;
    localparam int ORDER_ARB_FIFO_DEPTH = 3;

    typedef logic req_id_t;

    typedef struct packed {
        req_id_t                id;
        logic [ORDER_DSIZE-1:0] data0;
        logic [ORDER_DSIZE-1:0] data1;
        logic [ORDER_DSIZE-1:0] data2;
    } res_t;
endpackage

// File: rtl/order_arb3_fifo.sv
// 3-entry synchronous FIFO of result entries; head is registered storage, 0 latency on read.
// No internal flow control: the caller guarantees no push when full and no pop when empty.
module order_arb3_fifo
    import order_pkg::*;
#(
    parameter type entry_t = res_t
) (
    input  logic                                        clock,
    input  logic                                        rst_n,
    input  logic                                        push_i,
    input  entry_t                                      push_dat_i,
    input  logic                                        pop_i,
    output entry_t                                      head_o,
    output logic [$clog2(ORDER_ARB_FIFO_DEPTH+1)-1:0]   count_o
);
    localparam int PW = $clog2(ORDER_ARB_FIFO_DEPTH);
    localparam int CW = $clog2(ORDER_ARB_FIFO_DEPTH + 1);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;

    entry_t mem_q [ORDER_ARB_FIFO_DEPTH];
    ptr_t   wr_ptr_q, rd_ptr_q;
    cnt_t   count_q;

    function automatic ptr_t ptr_inc(input ptr_t p);
        return (p == ptr_t'(ORDER_ARB_FIFO_DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < ORDER_ARB_FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                mem_q[wr_ptr_q] <= push_dat_i;
                wr_ptr_q        <= ptr_inc(wr_ptr_q);
            end
            if (pop_i) rd_ptr_q <= ptr_inc(rd_ptr_q);
            unique case ({push_i, pop_i})
                2'b10:   count_q <= count_q + cnt_t'(1);
                2'b01:   count_q <= count_q - cnt_t'(1);
                default: ;
            endcase
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;
endmodule

// File: rtl/order_arb3.sv
// Two-requester round-robin scheduler for a registered descending 3-word sort; 2-cycle min latency.
// Issue is credit-gated by FIFO occupancy plus stage; ORDER_ARB_CNT_EN adds per-requester grant counters.
module order_arb3
    import order_pkg::*;
#(
    parameter int DSIZE = ORDER_DSIZE
`ifdef ORDER_ARB_CNT_EN
    ,
    parameter int CNTW  = 16
`endif
) (
    input  logic             clock,
    input  logic             rst_n,
    input  logic             req0_valid,
    output logic             req0_ready,
    input  logic [DSIZE-1:0] req0_data0,
    input  logic [DSIZE-1:0] req0_data1,
    input  logic [DSIZE-1:0] req0_data2,
    input  logic             req1_valid,
    output logic             req1_ready,
    input  logic [DSIZE-1:0] req1_data0,
    input  logic [DSIZE-1:0] req1_data1,
    input  logic [DSIZE-1:0] req1_data2,
    output logic             res_valid,
    input  logic             res_ready,
    output logic             res_id,
    output logic [DSIZE-1:0] res_data0,
    output logic [DSIZE-1:0] res_data1,
    output logic [DSIZE-1:0] res_data2
`ifdef ORDER_ARB_CNT_EN
    ,
    output logic [CNTW-1:0]  grant_cnt0,
    output logic [CNTW-1:0]  grant_cnt1
`endif
);
    localparam int CW = $clog2(ORDER_ARB_FIFO_DEPTH + 1);

    typedef struct packed {
        req_id_t          id;
        logic [DSIZE-1:0] data0;
        logic [DSIZE-1:0] data1;
        logic [DSIZE-1:0] data2;
    } res_w_t;

    req_id_t          last_grant_q, last_grant_d;
    res_w_t           stg_q, stg_d, head;
    logic             stg_vld_q, stg_vld_d;
    logic [CW-1:0]    fifo_cnt;
    logic             credit_ok, gnt0, gnt1, issue, pop;
    logic [DSIZE-1:0] s0, s1, s2;

    // Stage entry counts against credit so the FIFO can always absorb it next edge.
    assign credit_ok = (3'(fifo_cnt) + 3'(stg_vld_q)) < 3'(ORDER_ARB_FIFO_DEPTH);

    always_comb begin
        gnt0       = req0_valid & (~req1_valid | last_grant_q);
        gnt1       = req1_valid & (~req0_valid | ~last_grant_q);
        req0_ready = gnt0 & credit_ok;
        req1_ready = gnt1 & credit_ok;
        issue      = req0_ready | req1_ready;
    end

    // Bubble network with strict swaps: stable, so equal words keep input order.
    always_comb begin
        s0 = req1_ready ? req1_data0 : req0_data0;
        s1 = req1_ready ? req1_data1 : req0_data1;
        s2 = req1_ready ? req1_data2 : req0_data2;
        if (s1 > s0) {s0, s1} = {s1, s0};
        if (s2 > s1) {s1, s2} = {s2, s1};
        if (s1 > s0) {s0, s1} = {s1, s0};
    end

    always_comb begin
        last_grant_d = issue ? req_id_t'(req1_ready) : last_grant_q;
        stg_vld_d    = issue;
        stg_d        = stg_q;
        if (issue) stg_d = '{id: req_id_t'(req1_ready), data0: s0, data1: s1, data2: s2};
    end

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            stg_vld_q    <= 1'b0;
            stg_q        <= '0;
        end else begin
            last_grant_q <= last_grant_d;
            stg_vld_q    <= stg_vld_d;
            stg_q        <= stg_d;
        end
    end

    assign pop = res_valid & res_ready;

    order_arb3_fifo #(
        .entry_t (res_w_t)
    ) u_fifo (
        .clock      (clock),
        .rst_n      (rst_n),
        .push_i     (stg_vld_q),
        .push_dat_i (stg_q),
        .pop_i      (pop),
        .head_o     (head),
        .count_o    (fifo_cnt)
    );

    assign res_valid = (fifo_cnt != '0);
    assign res_id    = head.id;
    assign res_data0 = head.data0;
    assign res_data1 = head.data1;
    assign res_data2 = head.data2;

`ifdef ORDER_ARB_CNT_EN
    logic [CNTW-1:0] cnt0_q, cnt1_q;

    always_ff @(posedge clock or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (req0_ready) cnt0_q <= cnt0_q + CNTW'(1);
            if (req1_ready) cnt1_q <= cnt1_q + CNTW'(1);
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`else
    // Grant counters compiled out.
`endif
endmodule

// File: tb/tb_order_arb3.sv
// Directed self-checking bench for order_arb3; counter checks are active when ORDER_ARB_CNT_EN is defined.
module tb_order_arb3;
    logic       clock, rst_n;
    logic       req0_valid, req1_valid, res_ready;
    logic [7:0] req0_data0, req0_data1, req0_data2;
    logic [7:0] req1_data0, req1_data1, req1_data2;
    logic       req0_ready, req1_ready, res_valid, res_id;
    logic [7:0] res_data0, res_data1, res_data2;
    int         tests, fails;

`ifdef ORDER_ARB_CNT_EN
    logic [15:0] grant_cnt0, grant_cnt1;
    logic [1:0]  w_cnt0, w_cnt1;
    logic        w_r0, w_r1, w_vld, w_id;
    logic [7:0]  w_d0, w_d1, w_d2;

    order_arb3 #(.DSIZE(8), .CNTW(2)) u_dut_wrap (
        .clock(clock), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(w_r0),
        .req0_data0(req0_data0), .req0_data1(req0_data1), .req0_data2(req0_data2),
        .req1_valid(req1_valid), .req1_ready(w_r1),
        .req1_data0(req1_data0), .req1_data1(req1_data1), .req1_data2(req1_data2),
        .res_valid(w_vld), .res_ready(res_ready), .res_id(w_id),
        .res_data0(w_d0), .res_data1(w_d1), .res_data2(w_d2),
        .grant_cnt0(w_cnt0), .grant_cnt1(w_cnt1)
    );
`endif

    order_arb3 u_dut (
        .clock(clock), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_data0(req0_data0), .req0_data1(req0_data1), .req0_data2(req0_data2),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_data0(req1_data0), .req1_data1(req1_data1), .req1_data2(req1_data2),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_data0(res_data0), .res_data1(res_data1), .res_data2(res_data2)
`ifdef ORDER_ARB_CNT_EN
        ,
        .grant_cnt0(grant_cnt0), .grant_cnt1(grant_cnt1)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_res(input string tag, input bit v, input bit id,
                           input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2);
        if (v) chk(tag, {6'd0, res_valid, res_id, res_data0, res_data1, res_data2},
                        {6'd0, 1'b1, id, d0, d1, d2});
        else   chk(tag, 32'(res_valid), 32'd0);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive0(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req0_valid = v; req0_data0 = a; req0_data1 = b; req0_data2 = c;
    endtask

    task automatic drive1(input bit v, input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        req1_valid = v; req1_data0 = a; req1_data1 = b; req1_data2 = c;
    endtask

    logic [7:0] tr  [4][3];
    logic [7:0] tie [4][3];
    logic [7:0] tex [4][3];

    initial begin
        tests = 0; fails = 0;
        rst_n = 1'b0; res_ready = 1'b0;
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
        tr  = '{'{8'd1, 8'd2, 8'd3}, '{8'd4, 8'd5, 8'd6}, '{8'd7, 8'd8, 8'd9}, '{8'd0, 8'd0, 8'd1}};
        tie = '{'{8'd7, 8'd7, 8'd3}, '{8'd4, 8'd4, 8'd4}, '{8'd3, 8'd7, 8'd7}, '{8'd7, 8'd3, 8'd7}};
        tex = '{'{8'd7, 8'd7, 8'd3}, '{8'd4, 8'd4, 8'd4}, '{8'd7, 8'd7, 8'd3}, '{8'd7, 8'd7, 8'd3}};
        #12;
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res_word", {7'd0, res_id, res_data0, res_data1, res_data2}, 32'd0);
        chk("rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(negedge clock); rst_n = 1'b1;
        tick();

        // Contention: alternate 0,1,0,1 starting with req0.
        res_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            drive0(c < 4, 8'd10, 8'd20, 8'd30);
            drive1(c < 4, 8'd40, 8'd50, 8'd60);
            #1;
            if (c < 4) chk($sformatf("alt_ready_%0d", c), {30'd0, req0_ready, req1_ready},
                           (c % 2 == 0) ? 32'd2 : 32'd1);
            if (c >= 2) begin
                if ((c - 2) % 2 == 0) chk_res($sformatf("alt_res_%0d", c), 1, 0, 8'd30, 8'd20, 8'd10);
                else                  chk_res($sformatf("alt_res_%0d", c), 1, 1, 8'd60, 8'd50, 8'd40);
            end else chk_res($sformatf("alt_res_%0d", c), 0, 0, 0, 0, 0);
            tick();
        end

        // Single req0 triplet, 2-cycle latency.
        drive0(1, 8'd5, 8'd9, 8'd2); #1;
        chk("single_ready", {30'd0, req0_ready, req1_ready}, 32'd2);
        tick();
        drive0(0, 0, 0, 0); #1;
        chk_res("single_t1", 0, 0, 0, 0, 0);
        tick();
        chk_res("single_t2", 1, 0, 8'd9, 8'd5, 8'd2);
        tick();
        chk_res("single_t3", 0, 0, 0, 0, 0);

        // Backpressure: 3 accepts, then hold; drain and accept the 4th.
        res_ready = 1'b0;
        for (int c = 0; c < 6; c++) begin
            drive0(1, tr[c < 3 ? c : 3][0], tr[c < 3 ? c : 3][1], tr[c < 3 ? c : 3][2]);
            #1;
            chk($sformatf("bp_ready_%0d", c), {30'd0, req0_ready, req1_ready}, (c < 3) ? 32'd2 : 32'd0);
            if (c >= 3) chk_res($sformatf("bp_hold_%0d", c), 1, 0, 8'd3, 8'd2, 8'd1);
            tick();
        end
        res_ready = 1'b1; #1;
        chk("bp_ready_6", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk_res("bp_head_6", 1, 0, 8'd3, 8'd2, 8'd1);
        tick();
        chk("bp_ready_7", {30'd0, req0_ready, req1_ready}, 32'd2);
        chk_res("bp_head_7", 1, 0, 8'd6, 8'd5, 8'd4);
        tick();
        drive0(0, 0, 0, 0); #1;
        chk_res("bp_head_8", 1, 0, 8'd9, 8'd8, 8'd7);
        tick();
        chk_res("bp_head_9", 1, 0, 8'd1, 8'd0, 8'd0);
        tick();
        chk_res("bp_empty", 0, 0, 0, 0, 0);

        // Ties via req1.
        for (int c = 0; c < 6; c++) begin
            drive1(c < 4, tie[c < 4 ? c : 0][0], tie[c < 4 ? c : 0][1], tie[c < 4 ? c : 0][2]);
            #1;
            if (c < 4) chk($sformatf("tie_ready_%0d", c), {30'd0, req0_ready, req1_ready}, 32'd1);
            if (c >= 2) chk_res($sformatf("tie_res_%0d", c), 1, 1, tex[c-2][0], tex[c-2][1], tex[c-2][2]);
            tick();
        end
        drive1(0, 0, 0, 0); #1;
        chk_res("tie_empty", 0, 0, 0, 0, 0);

        // Reset with 2 buffered + 1 in stage.
        res_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            drive0(1, 8'(c + 1), 8'(c + 1), 8'(c + 1));
            tick();
        end
        #1;
        chk("pre_rst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        chk_res("pre_rst_head", 1, 0, 8'd1, 8'd1, 8'd1);
        drive0(0, 0, 0, 0);
        rst_n = 1'b0; #1;
        chk("arst_res_valid", 32'(res_valid), 32'd0);
        chk("arst_res_word", {7'd0, res_id, res_data0, res_data1, res_data2}, 32'd0);
        chk("arst_ready", {30'd0, req0_ready, req1_ready}, 32'd0);
        @(negedge clock); rst_n = 1'b1;
        tick(); tick();
        chk_res("post_rst_empty", 0, 0, 0, 0, 0);

        // 6 contention cycles then 2 req0-only: 5 req0, 3 req1 accepts.
        res_ready = 1'b1;
        for (int c = 0; c < 8; c++) begin
            drive0(1, 8'd1, 8'd2, 8'd3);
            drive1(c < 6, 8'd6, 8'd5, 8'd4);
            #1;
            chk($sformatf("post_ready_%0d", c), {30'd0, req0_ready, req1_ready},
                (c < 6 && c % 2 == 1) ? 32'd1 : 32'd2);
            if (c >= 2) begin
                if ((c - 2) % 2 == 0) chk_res($sformatf("post_res_%0d", c), 1, 0, 8'd3, 8'd2, 8'd1);
                else                  chk_res($sformatf("post_res_%0d", c), 1, 1, 8'd6, 8'd5, 8'd4);
            end
            tick();
        end
        drive0(0, 0, 0, 0); drive1(0, 0, 0, 0);
        tick(); tick(); tick();
        chk_res("final_empty", 0, 0, 0, 0, 0);
`ifdef ORDER_ARB_CNT_EN
        chk("grant_cnt0", 32'(grant_cnt0), 32'd5);
        chk("grant_cnt1", 32'(grant_cnt1), 32'd3);
        chk("grant_cnt0_wrap", 32'(w_cnt0), 32'd1);
        chk("grant_cnt1_wrap", 32'(w_cnt1), 32'd3);
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
